// File: rtl/leb128_u32_stream_decoder_pkg.sv
// Shared types and constants for the LEB128 u32 stream decoder.
// Holds the FSM state enum, the byte window size and the continuation bit index.
package leb128_u32_stream_decoder_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  localparam int MAX_BYTES = 5;
  localparam int CONT_BIT  = 7;
  localparam int WIN_W     = 8 * MAX_BYTES;

endpackage

// File: rtl/leb128_u32_stream_decoder_unpack.sv
// Combinational LEB128 unpack of a 5-byte window, byte 0 in the MSB slot.
// Value is the low N bits of the payload sum; len is terminator index + 1 (5 if none).
module unpack_unsigned
  import leb128_u32_stream_decoder_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [WIN_W-1:0] win,
  output logic [N-1:0]     value,
  output logic [2:0]       len
);

  logic [7*MAX_BYTES-1:0] acc;
  logic                   unused_hi;

  // Gather the 7-bit payloads, byte 0 least significant.
  always_comb begin
    acc = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      acc[7*i +: 7] = win[8*(MAX_BYTES-1-i) +: 7];
    end
  end

  assign value     = acc[N-1:0];
  assign unused_hi = ^acc[7*MAX_BYTES-1:N];

  // Length is set by the first byte with a clear continuation flag.
  always_comb begin
    len = 3'(MAX_BYTES);
    for (int i = MAX_BYTES - 1; i >= 0; i--) begin
      if (!win[8*(MAX_BYTES-1-i) + CONT_BIT]) begin
        len = 3'(i + 1);
      end
    end
  end

endmodule

// File: rtl/leb128_u32_stream_decoder.sv
// Streaming LEB128 unsigned 32-bit decoder with valid/ready on both sides.
// Define LEB128_ERR_CHECK_EN to flag overlong and overflowing encodings.
module leb128_u32_stream_decoder
  import leb128_u32_stream_decoder_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic [2:0]   out_len,
  output logic         out_err,
  output logic         out_valid,
  input  logic         out_ready
);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             err_q, err_d;

  logic [N-1:0]     dec_value;
  logic [2:0]       dec_len;
  logic             fire_in;
  logic             last;
  logic             cont;
  logic             emit;

  unpack_unsigned #(.N(N)) u_unpack (
    .win   (win_q),
    .value (dec_value),
    .len   (dec_len)
  );

  assign emit      = (state_q == EMIT);
  assign in_ready  = !emit;
  assign out_valid = emit;
  assign out_data  = emit ? dec_value : '0;
  assign out_len   = emit ? cnt_q : 3'd0;
  assign out_err   = emit & err_q;

  assign fire_in = in_valid && in_ready;
  assign last    = (cnt_q == 3'(MAX_BYTES - 1));
  assign cont    = in_data[CONT_BIT];

  // Next-state: collect bytes, emit on terminator, drain overlong tails.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    err_d   = err_q;
    unique case (state_q)
      COLLECT: begin
        if (fire_in) begin
          for (int i = 0; i < MAX_BYTES; i++) begin
            if (cnt_q == 3'(i)) begin
              win_d[8*(MAX_BYTES-1-i) +: 8] = in_data;
            end
          end
          cnt_d = cnt_q + 3'd1;
`ifdef LEB128_ERR_CHECK_EN
          if (last && cont) begin
            state_d = DRAIN;
            win_d   = '0;
          end else if (!cont) begin
            state_d = EMIT;
            err_d   = last && (|in_data[6:4]);
          end
`else
          if (!cont || last) begin
            state_d = EMIT;
          end
`endif
        end
      end
      DRAIN: begin
        if (fire_in && !cont) begin
          state_d = EMIT;
          err_d   = 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_d = COLLECT;
          cnt_d   = '0;
          win_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = COLLECT;
        cnt_d   = '0;
        win_d   = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      win_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      err_q   <= err_d;
    end
  end

`ifndef SYNTHESIS
  a_len_xcheck: assert property (
    @(posedge clk) disable iff (rst)
    (emit && !err_q) |-> (dec_len == cnt_q)
  );
`endif

endmodule

// File: tb/tb_leb128_u32_stream_decoder.sv
// Directed self-checking bench for the LEB128 u32 stream decoder.
// Error-check cases run when LEB128_ERR_CHECK_EN is defined.
module tb_leb128_u32_stream_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [2:0]  out_len;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  int total;
  int bad;

  leb128_u32_stream_decoder #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    chk("push_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] d,
                            input logic [2:0] l, input logic e);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_len"}, 32'(out_len), 32'(l));
    chk({tag, "_err"}, 32'(out_err), 32'(e));
    chk({tag, "_inrdy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic pop(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_popped"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_len", 32'(out_len), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_inrdy", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single zero byte, one cycle latency.
    push(8'h00);
    expect_out("zero", 32'd0, 3'd1, 1'b0);
    pop("zero");

    // Classic three-byte example.
    push(8'hE5);
    chk("mid_valid", 32'(out_valid), 32'd0);
    push(8'h8E);
    push(8'h26);
    expect_out("ex3", 32'd624485, 3'd3, 1'b0);
    pop("ex3");

    // Max value, held under backpressure with a stalled input byte.
    push(8'hFF);
    push(8'hFF);
    push(8'hFF);
    push(8'hFF);
    push(8'h0F);
    in_data  = 8'h2A;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      expect_out("hold", 32'hFFFF_FFFF, 3'd5, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("rel_valid", 32'(out_valid), 32'd0);
    push(8'h2A);
    expect_out("stall", 32'd42, 3'd1, 1'b0);
    pop("stall");

    // Reset in mid-sequence discards the partial value.
    push(8'hE5);
    push(8'h8E);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    push(8'h2A);
    expect_out("mrst", 32'd42, 3'd1, 1'b0);
    pop("mrst");
    @(negedge clk);
    chk("mrst_nostale", 32'(out_valid), 32'd0);

    // Reset during EMIT drops the pending result.
    push(8'h05);
    chk("erst_pre", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("erst_valid", 32'(out_valid), 32'd0);
    chk("erst_data", out_data, 32'd0);

    // Two-byte value 300.
    push(8'hAC);
    push(8'h02);
    expect_out("v300", 32'd300, 3'd2, 1'b0);
    pop("v300");

`ifdef LEB128_ERR_CHECK_EN
    for (int i = 0; i < 5; i++) push(8'h80);
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_inrdy", 32'(in_ready), 32'd1);
    push(8'h81);
    chk("drain2_valid", 32'(out_valid), 32'd0);
    push(8'h00);
    expect_out("ovl", 32'd0, 3'd5, 1'b1);
    pop("ovl");

    for (int i = 0; i < 4; i++) push(8'hFF);
    push(8'h7F);
    expect_out("ovf", 32'hFFFF_FFFF, 3'd5, 1'b1);
    pop("ovf");
`else
    for (int i = 0; i < 5; i++) push(8'h80);
    expect_out("term5", 32'd0, 3'd5, 1'b0);
    pop("term5");

    for (int i = 0; i < 4; i++) push(8'hFF);
    push(8'h7F);
    expect_out("trunc", 32'hFFFF_FFFF, 3'd5, 1'b0);
    pop("trunc");
`endif

    // Clean value after the edge cases.
    push(8'h01);
    expect_out("after", 32'd1, 3'd1, 1'b0);
    pop("after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/leb128_u32_stream_decoder.md
LEB128_U32_STREAM_DECODER -- requirements
Module: leb128_u32_stream_decoder

Interface
REQ-001 Parameter: N, 32, decoded value width; only 32 supported, window fixed at 5 bytes.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_data  input  8  LEB128 byte; bit 7 is the continuation flag, bits 6:0 are payload.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_ready  output  1  decoder accepts a byte this cycle.
REQ-007 out_data  output  32  decoded unsigned value.
REQ-008 out_len  output  3  number of bytes consumed, 1..5.
REQ-009 out_err  output  1  malformed encoding flag.
REQ-010 out_valid  output  1  out_data, out_len and out_err are valid.
REQ-011 out_ready  input  1  consumer accepts the result.

Function
REQ-012 The block SHALL use states COLLECT, EMIT and DRAIN, with 3-bit byte count cnt and a 40-bit window, byte 0 in the MSB slot.
REQ-013 A byte SHALL be transferred only when in_valid and in_ready are both 1 on a clock edge.
REQ-014 in_ready SHALL be 1 in COLLECT and DRAIN and 0 in EMIT; out_valid SHALL be 1 only in EMIT.
REQ-015 In COLLECT, an accepted byte SHALL be written to window slot cnt, and cnt SHALL increment.
REQ-016 In COLLECT, an accepted byte with bit7=0 SHALL move the state to EMIT; that byte is the terminator.
  - Slots above the terminator SHALL read as zero.
  - out_data SHALL be the LEB128 decode of the window.
  - out_len SHALL be cnt+1, with cnt taken before the increment.
REQ-017 Latency SHALL be one cycle: out_valid rises on the edge that accepts the terminator.
REQ-018 In EMIT, outputs SHALL hold stable until out_valid and out_ready are both 1 on an edge.
  - The state then returns to COLLECT, and the window and cnt clear.
  - Sustained throughput SHALL be one value per len+1 cycles.
REQ-019 in_valid arriving while in EMIT SHALL be stalled, never dropped.
REQ-020 Payload bits of byte 5 above bit 3 SHALL be discarded from out_data, which is the low 32 bits.

Reset
REQ-021 With rst=1 at an edge, the block SHALL return to COLLECT, clear cnt and the window, and drive out_valid=0, out_data=0, out_len=0 and out_err=0.
REQ-022 A reset in mid-sequence or mid-EMIT SHALL discard partial or pending results; nothing is emitted for them.

Configuration
REQ-023 The macro LEB128_ERR_CHECK_EN SHALL control error checking.
REQ-024 With LEB128_ERR_CHECK_EN defined, the block SHALL flag two error cases:
  - 5th byte with bit7=1 (overlong): enter DRAIN, discard bytes until one with bit7=0 is accepted, then EMIT with out_err=1, out_data=0, out_len=5.
  - 5th byte with bit7=0 and bits 6:4 nonzero (overflow): EMIT with out_err=1, out_data truncated as in REQ-020, out_len=5.
REQ-025 Without LEB128_ERR_CHECK_EN, the block SHALL behave as follows:
  - out_err is tied to 0 and DRAIN is never entered.
  - The 5th accepted byte always terminates, regardless of bit7.

Structure
REQ-026 A shared package SHALL hold the state enum, MAX_BYTES=5, and the continuation-bit index 7.
REQ-027 The decode SHALL instantiate the existing combinational unpack_unsigned #(.N(32)) on the 40-bit window as its single sub-module.
  - Its len output SHALL be used only as a cross-check in simulation.

Verification
REQ-028 Byte 0x00 -> out_data=0, out_len=1, out_err=0, out_valid one cycle after acceptance.
REQ-029 Bytes 0xE5, 0x8E, 0x26 back-to-back -> out_data=624485, out_len=3.
REQ-030 Bytes 0xFF, 0xFF, 0xFF, 0xFF, 0x0F, with out_ready=0 for 4 cycles -> the following SHALL hold:
  - out_data=0xFFFFFFFF and out_len=5, stable for those 4 cycles.
  - in_ready=0 throughout, and the next byte 0x2A yields 42 after release.
REQ-031 With LEB128_ERR_CHECK_EN: bytes 0x80 x5 then 0x00 -> out_err=1, out_data=0; bytes FF FF FF FF 7F -> out_err=1, out_data=0xFFFFFFFF.
REQ-032 Bytes 0xE5, 0x8E, then rst=1 for one cycle, then 0x2A -> a single output of 42 with out_len=1 and no stale value.
